// File: rtl/serial_channel_receiver.sv
// Serial frame receiver: start, address, length, data bits, stop.
// Data bits are forwarded with a one-hot per-channel valid.
module serial_channel_receiver #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 4,
    localparam int NCH   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              SerIn,
    output logic              SerOut,
    output logic [NCH-1:0]    SerOutValid,
    output logic [ADDR_W-1:0] ChAddr,
    output logic              Busy,
    output logic              Done,
    output logic              FrameErr
);

    localparam int BW = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t            state;
    logic [BW-1:0]     bitcnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [ADDR_W-1:0] addr_nx;
    logic [LEN_W-1:0]  len_sr;
    logic [LEN_W-1:0]  len_nx;
    logic [LEN_W-1:0]  datacnt;

    // Field value including the bit on the line this tick (MSB first).
    assign addr_nx = (addr_sr << 1) | ADDR_W'(SerIn);
    assign len_nx  = (len_sr << 1) | LEN_W'(SerIn);

    // Data forwarding is a pure decode of the current state and tick.
    assign SerOut      = (state == DATA) ? SerIn : 1'b0;
    assign SerOutValid = (state == DATA && clkEn) ? (NCH'(1) << ChAddr) : '0;

    // Frame FSM; Done/FrameErr/Busy are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bitcnt   <= '0;
            addr_sr  <= '0;
            len_sr   <= '0;
            datacnt  <= '0;
            ChAddr   <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            Done     <= 1'b0;
            FrameErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clkEn && !SerIn) begin
                        state   <= ADDR;
                        bitcnt  <= '0;
                        addr_sr <= '0;
                        len_sr  <= '0;
                        Busy    <= 1'b1;
                    end
                end
                ADDR: begin
                    if (clkEn) begin
                        addr_sr <= addr_nx;
                        if (bitcnt == BW'(ADDR_W - 1)) begin
                            ChAddr <= addr_nx;
                            bitcnt <= '0;
                            state  <= LEN;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end
                end
                LEN: begin
                    if (clkEn) begin
                        len_sr <= len_nx;
                        if (bitcnt == BW'(LEN_W - 1)) begin
                            datacnt <= len_nx;
                            state   <= (len_nx == '0) ? STOP : DATA;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end
                end
                DATA: begin
                    if (clkEn) begin
                        datacnt <= datacnt - LEN_W'(1);
                        if (datacnt == LEN_W'(1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (clkEn) begin
                        Done     <= 1'b1;
                        FrameErr <= ~SerIn;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_channel_receiver.sv
// Bench for serial_channel_receiver: directed spec frames plus random
// frame streams checked against a frame-parsing reference model.
module tb_serial_channel_receiver;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 4;
    localparam int NCH    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clkEn;
    logic              SerIn;
    logic              SerOut;
    logic [NCH-1:0]    SerOutValid;
    logic [ADDR_W-1:0] ChAddr;
    logic              Busy;
    logic              Done;
    logic              FrameErr;

    int checks = 0;
    int errors = 0;

    int stream[$];
    int ob_bit[$];
    int ob_ch[$];
    int ob_done[$];
    int ob_err[$];
    int ob_busy[$];
    int ex_bit[$];
    int ex_ch[$];
    int ex_done[$];
    int ex_err[$];
    int ex_addr = 0;
    int bad_shape;

    always #5 clk = ~clk;

    serial_channel_receiver #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk),
        .rst(rst),
        .clkEn(clkEn),
        .SerIn(SerIn),
        .SerOut(SerOut),
        .SerOutValid(SerOutValid),
        .ChAddr(ChAddr),
        .Busy(Busy),
        .Done(Done),
        .FrameErr(FrameErr)
    );

    // Append one frame; data bits d sent MSB first (first sent = bit l-1).
    function automatic void add_frame(input int a, input int l,
                                      input int d, input int sb);
        stream.push_back(0);
        for (int k = ADDR_W - 1; k >= 0; k--) stream.push_back((a >> k) & 1);
        for (int k = LEN_W - 1; k >= 0; k--) stream.push_back((l >> k) & 1);
        for (int k = l - 1; k >= 0; k--) stream.push_back((d >> k) & 1);
        stream.push_back(sb);
    endfunction

    // Reference: parse the bit stream into frames. Stream bit j is
    // presented on tick window j*per; Done shows one window after stop.
    // The window right after the stop tick is the DONE cycle, so at
    // per==1 the stream slot there is never seen by the receiver.
    function automatic void model(input int per);
        int j;
        int a;
        int l;
        ex_bit.delete();
        ex_ch.delete();
        ex_done.delete();
        ex_err.delete();
        j = 0;
        while (j < stream.size()) begin
            if (stream[j] == 1) begin
                j++;
            end else begin
                a = 0;
                l = 0;
                j++;
                for (int k = 0; k < ADDR_W; k++) begin
                    a = a * 2 + stream[j];
                    j++;
                end
                for (int k = 0; k < LEN_W; k++) begin
                    l = l * 2 + stream[j];
                    j++;
                end
                for (int k = 0; k < l; k++) begin
                    ex_bit.push_back(stream[j]);
                    ex_ch.push_back(a);
                    j++;
                end
                ex_done.push_back(j * per + 1);
                ex_err.push_back(stream[j] == 0 ? 1 : 0);
                ex_addr = a;
                j++;
                if (per == 1) j++;
            end
        end
    endfunction

    function automatic string ev_str(input int b[$], input int c[$]);
        string s;
        s = "";
        for (int k = 0; k < b.size(); k++)
            s = {s, $sformatf("%0d@%0d ", b[k], c[k])};
        return s;
    endfunction

    function automatic string q_str(input int q[$]);
        string s;
        s = "";
        for (int k = 0; k < q.size(); k++)
            s = {s, $sformatf("%0d ", q[k])};
        return s;
    endfunction

    // Drive the stream with a tick every per clocks, random line between
    // ticks, and record what the receiver produced in each window.
    task automatic drive(input int per);
        int nw;
        int ch;
        ob_bit.delete();
        ob_ch.delete();
        ob_done.delete();
        ob_err.delete();
        ob_busy.delete();
        bad_shape = 0;
        nw = stream.size() * per + 4;
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            if (w % per == 0) begin
                clkEn = 1'b1;
                SerIn = (w / per < stream.size()) ? stream[w / per][0] : 1'b1;
            end else begin
                clkEn = 1'b0;
                SerIn = 1'($urandom_range(0, 1));
            end
            #1;
            ob_busy.push_back(int'(Busy));
            if (SerOutValid != '0) begin
                if (!clkEn || $countones(SerOutValid) != 1) bad_shape++;
                ch = 0;
                for (int k = 0; k < NCH; k++) if (SerOutValid[k]) ch = k;
                ob_bit.push_back(int'(SerOut));
                ob_ch.push_back(ch);
            end
            if (Done) begin
                ob_done.push_back(w);
                ob_err.push_back(int'(FrameErr));
            end else if (FrameErr) begin
                bad_shape++;
            end
        end
        clkEn = 1'b0;
        SerIn = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clkEn = 1'b0;
        SerIn = 1'b1;
        repeat (3) @(negedge clk);
        clkEn = 1'b1;
        #1;
        checks++;
        if ({SerOut, SerOutValid, ChAddr, Busy, Done, FrameErr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {SerOut, SerOutValid, ChAddr, Busy, Done, FrameErr});
        end
        @(negedge clk);
        rst = 1'b1;
        clkEn = 1'b0;
        ex_addr = 0;
    endtask

    task automatic test_basic();
        stream.delete();
        add_frame(2, 3, 5, 1);
        repeat (2) stream.push_back(1);
        model(1);
        drive(1);
        checks++;
        if (ev_str(ob_bit, ob_ch) != "1@2 0@2 1@2 ") begin
            errors++;
            $display("FAIL basic_data got '%s' want '1@2 0@2 1@2 '",
                     ev_str(ob_bit, ob_ch));
        end
        checks++;
        if (q_str(ob_done) != "11 " || q_str(ex_done) != "11 ") begin
            errors++;
            $display("FAIL basic_done got '%s' want '11 '", q_str(ob_done));
        end
        checks++;
        if (q_str(ob_err) != "0 ") begin
            errors++;
            $display("FAIL basic_err got '%s' want '0 '", q_str(ob_err));
        end
        checks++;
        if (ChAddr !== 2'd2) begin
            errors++;
            $display("FAIL basic_chaddr got %0d want 2", ChAddr);
        end
        checks++;
        if (ob_busy[1] != 1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got %0d/%0d want 1/0", ob_busy[1], Busy);
        end
        checks++;
        if (bad_shape != 0) begin
            errors++;
            $display("FAIL basic_shape got %0d want 0", bad_shape);
        end
    endtask

    task automatic test_slow_tick();
        stream.delete();
        add_frame(2, 3, 5, 1);
        repeat (2) stream.push_back(1);
        model(4);
        drive(4);
        checks++;
        if (ev_str(ob_bit, ob_ch) != "1@2 0@2 1@2 ") begin
            errors++;
            $display("FAIL slow_data got '%s' want '1@2 0@2 1@2 '",
                     ev_str(ob_bit, ob_ch));
        end
        checks++;
        if (q_str(ob_done) != q_str(ex_done)) begin
            errors++;
            $display("FAIL slow_done got '%s' want '%s'",
                     q_str(ob_done), q_str(ex_done));
        end
        checks++;
        if (bad_shape != 0 || q_str(ob_err) != "0 ") begin
            errors++;
            $display("FAIL slow_shape got %0d '%s' want 0 '0 '",
                     bad_shape, q_str(ob_err));
        end
    endtask

    task automatic test_zero_len();
        stream.delete();
        add_frame(1, 0, 0, 1);
        repeat (2) stream.push_back(1);
        model(1);
        drive(1);
        checks++;
        if (ob_bit.size() != 0) begin
            errors++;
            $display("FAIL zero_len_valids got %0d want 0", ob_bit.size());
        end
        checks++;
        if (ChAddr !== 2'd1) begin
            errors++;
            $display("FAIL zero_len_chaddr got %0d want 1", ChAddr);
        end
        checks++;
        if (q_str(ob_done) != q_str(ex_done) || q_str(ob_err) != "0 ") begin
            errors++;
            $display("FAIL zero_len_done got '%s' '%s' want '%s' '0 '",
                     q_str(ob_done), q_str(ob_err), q_str(ex_done));
        end
    endtask

    task automatic test_bad_stop();
        stream.delete();
        add_frame(3, 2, 3, 0);
        repeat (2) stream.push_back(1);
        model(1);
        drive(1);
        checks++;
        if (ev_str(ob_bit, ob_ch) != "1@3 1@3 ") begin
            errors++;
            $display("FAIL bad_stop_data got '%s' want '1@3 1@3 '",
                     ev_str(ob_bit, ob_ch));
        end
        checks++;
        if (q_str(ob_done) != q_str(ex_done) || q_str(ob_err) != "1 ") begin
            errors++;
            $display("FAIL bad_stop_err got '%s' '%s' want '%s' '1 '",
                     q_str(ob_done), q_str(ob_err), q_str(ex_done));
        end
        checks++;
        if (bad_shape != 0) begin
            errors++;
            $display("FAIL bad_stop_shape got %0d want 0", bad_shape);
        end
    endtask

    task automatic test_reset_mid();
        stream.delete();
        add_frame(2, 4, 9, 1);
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            clkEn = 1'b1;
            SerIn = stream[w][0];
        end
        #1;
        checks++;
        if (SerOutValid !== 4'b0100) begin
            errors++;
            $display("FAIL mid_valid got %b want 0100", SerOutValid);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({SerOut, SerOutValid, ChAddr, Busy, Done, FrameErr} !== '0) begin
            errors++;
            $display("FAIL mid_reset got %b want 0",
                     {SerOut, SerOutValid, ChAddr, Busy, Done, FrameErr});
        end
        @(negedge clk);
        rst = 1'b1;
        clkEn = 1'b0;
        SerIn = 1'b1;
        ex_addr = 0;
        stream.delete();
        add_frame(1, 1, 1, 1);
        repeat (2) stream.push_back(1);
        model(1);
        drive(1);
        checks++;
        if (ev_str(ob_bit, ob_ch) != "1@1 " || ChAddr !== 2'd1) begin
            errors++;
            $display("FAIL after_reset got '%s' ch %0d want '1@1 ' ch 1",
                     ev_str(ob_bit, ob_ch), ChAddr);
        end
        checks++;
        if (q_str(ob_done) != q_str(ex_done)) begin
            errors++;
            $display("FAIL after_reset_done got '%s' want '%s'",
                     q_str(ob_done), q_str(ex_done));
        end
    endtask

    task automatic test_back_to_back();
        stream.delete();
        add_frame(3, 15, int'($urandom_range(0, 32767)), 1);
        stream.push_back(1);
        add_frame(0, 15, int'($urandom_range(0, 32767)), 1);
        repeat (2) stream.push_back(1);
        model(1);
        drive(1);
        checks++;
        if (ev_str(ob_bit, ob_ch) != ev_str(ex_bit, ex_ch) || ob_bit.size() != 30) begin
            errors++;
            $display("FAIL b2b_data got '%s' want '%s'",
                     ev_str(ob_bit, ob_ch), ev_str(ex_bit, ex_ch));
        end
        checks++;
        if (q_str(ob_done) != q_str(ex_done) || ob_done.size() != 2) begin
            errors++;
            $display("FAIL b2b_done got '%s' want '%s'",
                     q_str(ob_done), q_str(ex_done));
        end
        checks++;
        if (ChAddr !== 2'd0 || q_str(ob_err) != "0 0 ") begin
            errors++;
            $display("FAIL b2b_tail got ch %0d err '%s' want ch 0 err '0 0 '",
                     ChAddr, q_str(ob_err));
        end
    endtask

    task automatic test_random();
        int per;
        int l;
        for (int it = 0; it < 10; it++) begin
            per = int'($urandom_range(1, 4));
            stream.delete();
            repeat (int'($urandom_range(0, 2))) stream.push_back(1);
            repeat (int'($urandom_range(1, 2))) begin
                l = int'($urandom_range(0, 15));
                add_frame(int'($urandom_range(0, 3)), l,
                          int'($urandom & ((1 << l) - 1)),
                          ($urandom_range(0, 3) != 0) ? 1 : 0);
                repeat (int'($urandom_range(1, 2))) stream.push_back(1);
            end
            stream.push_back(1);
            model(per);
            drive(per);
            checks++;
            if (ev_str(ob_bit, ob_ch) != ev_str(ex_bit, ex_ch)) begin
                errors++;
                $display("FAIL rand%0d_data got '%s' want '%s'", it,
                         ev_str(ob_bit, ob_ch), ev_str(ex_bit, ex_ch));
            end
            checks++;
            if (q_str(ob_done) != q_str(ex_done) || q_str(ob_err) != q_str(ex_err)) begin
                errors++;
                $display("FAIL rand%0d_done got '%s' '%s' want '%s' '%s'", it,
                         q_str(ob_done), q_str(ob_err),
                         q_str(ex_done), q_str(ex_err));
            end
            checks++;
            if (ChAddr !== 2'(ex_addr) || bad_shape != 0) begin
                errors++;
                $display("FAIL rand%0d_addr got %0d/%0d want %0d/0", it,
                         ChAddr, bad_shape, ex_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_tick();
        test_zero_len();
        test_bad_stop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
